// File: rtl/exception_sequencer_if.sv
// Request/commit bundle between the pipeline, the trap sequencer, CP0 and the PC register.
interface exception_sequencer_if;
  logic        req_syscall;
  logic        req_break;
  logic        req_teq;
  logic        irq_in;
  logic        req_eret;
  logic [31:0] req_pc;
  logic [31:0] status_in;
  logic [31:0] epc_in;
  logic        cp0_exception;
  logic        cp0_eret;
  logic [4:0]  cp0_cause;
  logic [31:0] cp0_pc;
  logic        pipe_stall;
  logic        pipe_flush;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        busy;

  modport master (
    output req_syscall, req_break, req_teq, irq_in, req_eret, req_pc, status_in, epc_in,
    input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, pipe_stall, pipe_flush,
           pc_load, pc_target, busy
  );

  modport slave (
    input  req_syscall, req_break, req_teq, irq_in, req_eret, req_pc, status_in, epc_in,
    output cp0_exception, cp0_eret, cp0_cause, cp0_pc, pipe_stall, pipe_flush,
           pc_load, pc_target, busy
  );
endinterface

// File: rtl/exception_sequencer.sv
// Fixed-priority trap arbiter that sequences exception/ERET commits into CP0,
// stalls and flushes the pipeline, and redirects the PC.
module exception_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004
) (
  input logic                  clk_in,
  input logic                  reset_in,
  exception_sequencer_if.slave seq_if
);

  typedef enum logic [2:0] {IDLE, COMMIT, FLUSH, REDIRECT, ERET} state_e;

  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;

  logic        exc_o, eret_o, stall_o, flush_o, load_o;
  logic [4:0]  cause_o;
  logic [31:0] epc_o, target_o;

  logic        gie, en_sys, en_brk, en_teq, en_irq;
  logic        unused_status;

  assign gie    = seq_if.status_in[0];
  assign en_sys = gie & seq_if.status_in[1] & seq_if.req_syscall;
  assign en_brk = gie & seq_if.status_in[2] & seq_if.req_break;
  assign en_teq = gie & seq_if.status_in[3] & seq_if.req_teq;
  assign en_irq = gie & seq_if.status_in[4] & seq_if.irq_in;
  assign unused_status = ^seq_if.status_in[31:5];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    pc_d     = pc_q;
    exc_o    = 1'b0;
    eret_o   = 1'b0;
    stall_o  = 1'b0;
    flush_o  = 1'b0;
    load_o   = 1'b0;
    cause_o  = '0;
    epc_o    = '0;
    target_o = '0;
    case (state_q)
      IDLE: begin
        // Arbitration order doubles as priority: the first eligible source wins.
        if (en_sys) begin
          state_d = COMMIT; cause_d = 5'd8;  pc_d = seq_if.req_pc;
        end else if (en_brk) begin
          state_d = COMMIT; cause_d = 5'd9;  pc_d = seq_if.req_pc;
        end else if (en_teq) begin
          state_d = COMMIT; cause_d = 5'd13; pc_d = seq_if.req_pc;
        end else if (en_irq) begin
          state_d = COMMIT; cause_d = 5'd0;  pc_d = seq_if.req_pc;
        end else if (seq_if.req_eret) begin
          state_d = ERET;
        end
      end
      COMMIT: begin
        exc_o   = 1'b1;
        stall_o = 1'b1;
        flush_o = 1'b1;
        cause_o = cause_q;
        epc_o   = pc_q;
        cnt_d   = FlushInit;
        state_d = FLUSH;
      end
      FLUSH: begin
        stall_o = 1'b1;
        if (cnt_q == 4'd0) state_d = REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      REDIRECT: begin
        stall_o  = 1'b1;
        load_o   = 1'b1;
        target_o = EXC_VECTOR;
        state_d  = IDLE;
      end
      ERET: begin
        eret_o   = 1'b1;
        load_o   = 1'b1;
        stall_o  = 1'b1;
        flush_o  = 1'b1;
        target_o = seq_if.epc_in;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign seq_if.cp0_exception = exc_o;
  assign seq_if.cp0_eret      = eret_o;
  assign seq_if.cp0_cause     = cause_o;
  assign seq_if.cp0_pc        = epc_o;
  assign seq_if.pipe_stall    = stall_o;
  assign seq_if.pipe_flush    = flush_o;
  assign seq_if.pc_load       = load_o;
  assign seq_if.pc_target     = target_o;
  assign seq_if.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer with hand-computed expected strobe patterns.
module tb_exception_sequencer;

  logic clk_in;
  logic reset_in;
  int   tests;
  int   fails;

  exception_sequencer_if seq_if ();

  exception_sequencer #(
    .FLUSH_CYCLES (2),
    .EXC_VECTOR   (32'h0040_0004)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .seq_if   (seq_if.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Strobe vector order: {exception, eret, stall, flush, pc_load, busy}
  localparam logic [5:0] S_IDLE   = 6'b000000;
  localparam logic [5:0] S_COMMIT = 6'b101101;
  localparam logic [5:0] S_FLUSH  = 6'b001001;
  localparam logic [5:0] S_REDIR  = 6'b001011;
  localparam logic [5:0] S_ERET   = 6'b011111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {seq_if.cp0_exception, seq_if.cp0_eret, seq_if.pipe_stall,
            seq_if.pipe_flush, seq_if.pc_load, seq_if.busy};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_reqs();
    seq_if.req_syscall = 1'b0;
    seq_if.req_break   = 1'b0;
    seq_if.req_teq     = 1'b0;
    seq_if.irq_in      = 1'b0;
    seq_if.req_eret    = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_in = 1'b1;
    clear_reqs();
    seq_if.req_pc    = '0;
    seq_if.status_in = '0;
    seq_if.epc_in    = '0;
    #3;
    chk("reset_strobes", 32'(strobes()), 32'(S_IDLE));
    chk("reset_cause", 32'(seq_if.cp0_cause), 32'd0);
    step();
    step();
    reset_in = 1'b0;
    step();
    chk("post_reset_idle", 32'(strobes()), 32'(S_IDLE));

    // Syscall, FLUSH_CYCLES=2: redirect four cycles after the request
    seq_if.status_in   = 32'h3;
    seq_if.req_syscall = 1'b1;
    seq_if.req_pc      = 32'h0040_0020;
    step();
    clear_reqs();
    chk("sys_commit", 32'(strobes()), 32'(S_COMMIT));
    chk("sys_cause", 32'(seq_if.cp0_cause), 32'd8);
    chk("sys_epc", seq_if.cp0_pc, 32'h0040_0020);
    step();
    chk("sys_flush1", 32'(strobes()), 32'(S_FLUSH));
    chk("sys_flush1_pc", seq_if.cp0_pc, 32'h0);
    step();
    chk("sys_flush2", 32'(strobes()), 32'(S_FLUSH));
    step();
    chk("sys_redirect", 32'(strobes()), 32'(S_REDIR));
    chk("sys_target", seq_if.pc_target, 32'h0040_0004);
    step();
    chk("sys_idle", 32'(strobes()), 32'(S_IDLE));
    chk("sys_idle_target", seq_if.pc_target, 32'h0);

    // Masked break, then enabled break
    seq_if.status_in = 32'h1;
    seq_if.req_break = 1'b1;
    seq_if.req_pc    = 32'h0040_0030;
    step();
    chk("brk_masked", 32'(strobes()), 32'(S_IDLE));
    seq_if.status_in = 32'h5;
    step();
    seq_if.req_break = 1'b0;
    chk("brk_commit", 32'(strobes()), 32'(S_COMMIT));
    chk("brk_cause", 32'(seq_if.cp0_cause), 32'd9);
    chk("brk_epc", seq_if.cp0_pc, 32'h0040_0030);
    step();
    step();
    step();
    chk("brk_redirect", 32'(strobes()), 32'(S_REDIR));
    step();

    // Priority: teq beats irq and eret; Status changes mid-sequence are ignored
    seq_if.status_in = 32'h1F;
    seq_if.req_teq   = 1'b1;
    seq_if.irq_in    = 1'b1;
    seq_if.req_eret  = 1'b1;
    seq_if.req_pc    = 32'h0040_0040;
    step();
    seq_if.req_teq  = 1'b0;
    seq_if.req_eret = 1'b0;
    chk("pri_commit", 32'(strobes()), 32'(S_COMMIT));
    chk("pri_cause", 32'(seq_if.cp0_cause), 32'd13);
    seq_if.status_in = 32'h0;
    step();
    chk("pri_flush1", 32'(strobes()), 32'(S_FLUSH));
    step();
    step();
    chk("pri_redirect", 32'(strobes()), 32'(S_REDIR));
    seq_if.status_in = 32'h1F;
    seq_if.req_pc    = 32'h0040_0044;
    step();
    chk("pri_idle_gap", 32'(strobes()), 32'(S_IDLE));
    step();
    seq_if.irq_in = 1'b0;
    chk("irq_commit", 32'(strobes()), 32'(S_COMMIT));
    chk("irq_cause", 32'(seq_if.cp0_cause), 32'd0);
    chk("irq_epc", seq_if.cp0_pc, 32'h0040_0044);

    // Break pulsed during FLUSH is ignored
    step();
    seq_if.req_break = 1'b1;
    step();
    seq_if.req_break = 1'b0;
    chk("busy_ignore_flush2", 32'(strobes()), 32'(S_FLUSH));
    step();
    chk("busy_ignore_redir", 32'(strobes()), 32'(S_REDIR));
    step();
    chk("busy_ignore_idle", 32'(strobes()), 32'(S_IDLE));
    step();
    chk("busy_ignore_idle2", 32'(strobes()), 32'(S_IDLE));

    // ERET is always eligible, even with Status cleared
    seq_if.status_in = 32'h0;
    seq_if.req_eret  = 1'b1;
    seq_if.epc_in    = 32'h0040_003C;
    step();
    seq_if.req_eret = 1'b0;
    chk("eret_strobes", 32'(strobes()), 32'(S_ERET));
    chk("eret_target", seq_if.pc_target, 32'h0040_003C);
    chk("eret_cause", 32'(seq_if.cp0_cause), 32'd0);
    step();
    chk("eret_idle", 32'(strobes()), 32'(S_IDLE));

    // Simultaneous syscall and irq: syscall first, irq retaken afterwards
    seq_if.status_in   = 32'h1F;
    seq_if.req_syscall = 1'b1;
    seq_if.irq_in      = 1'b1;
    step();
    seq_if.req_syscall = 1'b0;
    chk("simul_cause", 32'(seq_if.cp0_cause), 32'd8);
    step();
    step();
    step();
    step();
    chk("simul_gap", 32'(strobes()), 32'(S_IDLE));
    step();
    seq_if.irq_in = 1'b0;
    chk("simul_irq_cause", 32'(seq_if.cp0_cause), 32'd0);
    chk("simul_irq_commit", 32'(strobes()), 32'(S_COMMIT));

    // Reset during FLUSH: outputs clear asynchronously, no later redirect
    step();
    chk("rst_in_flush", 32'(strobes()), 32'(S_FLUSH));
    #2;
    reset_in = 1'b1;
    #1;
    chk("rst_async", 32'(strobes()), 32'(S_IDLE));
    step();
    reset_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_no_strobe", 32'(strobes()), 32'(S_IDLE));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Trap controller in front of `coprocessor0`. It accepts exception, interrupt and ERET requests from the pipeline, and arbitrates them by fixed priority. It gates each request with the CP0 Status enable bits, then sequences the commit into CP0: exception pulse, cause and EPC, pipeline stall/flush and PC redirect. It sits between the decode/execute stages, CP0 and the PC register.

## Interface
- `FLUSH_CYCLES`, 2: stall-only cycles between CP0 commit and PC redirect; legal range 1–15.
- `EXC_VECTOR`, 32'h00400004: handler entry address loaded on exception.
- `clk_in` input 1: clock, all state updates on rising edge.
- `reset_in` input 1: asynchronous, active-high reset.
- `req_syscall` input 1: syscall at `req_pc`; cause 8.
- `req_break` input 1: break at `req_pc`; cause 9.
- `req_teq` input 1: teq trap taken at `req_pc`; cause 13.
- `irq_in` input 1: external interrupt level; cause 0.
- `req_eret` input 1: eret instruction in execute.
- `req_pc` input 32: PC of the requesting instruction.
- `status_in` input 32: CP0 Status. Bit0 = global enable, bit1 = syscall enable, bit2 = break enable, bit3 = teq enable, bit4 = irq enable.
- `epc_in` input 32: CP0 exception-address output, valid while `cp0_eret`=1.
- `cp0_exception` output 1: exception strobe to CP0.
- `cp0_eret` output 1: eret strobe to CP0.
- `cp0_cause` output 5: cause code to CP0.
- `cp0_pc` output 32: EPC value to CP0.
- `pipe_stall` output 1: freeze fetch/decode/execute.
- `pipe_flush` output 1: squash instructions younger than the trapping one.
- `pc_load` output 1: load `pc_target` into PC this cycle.
- `pc_target` output 32: redirect address.
- `busy` output 1: state ≠ IDLE.

## Operation
- **States:** IDLE, COMMIT, FLUSH, REDIRECT, ERET.
- **Acceptance:** requests are sampled only in IDLE. While `busy`=1, requests are ignored; the pipeline is stalled and re-presents them.
- **Enable rule:** a source is eligible when `status_in[0]`=1 AND its enable bit = 1. `req_eret` is always eligible.
- **Fixed priority:** syscall > break > teq > irq > eret. Only the highest eligible request is taken; all others are dropped that cycle.
- **Masked sync exceptions:** no action; the state stays IDLE and the instruction completes normally.
- **IDLE → COMMIT (exception):** on the accepting edge, latch cause (8/9/13/0) and `req_pc` into internal registers.
- **COMMIT:**
  - Outputs: `cp0_exception`=1, `cp0_cause`/`cp0_pc` = latched values, `pipe_stall`=1, `pipe_flush`=1.
  - CP0 shifts Status left by 5 on this edge, disabling further traps.
  - Next state: FLUSH.
- **FLUSH:** `pipe_stall`=1. An internal counter runs from `FLUSH_CYCLES`-1 down to 0, then the state moves to REDIRECT.
- **REDIRECT:** `pipe_stall`=1, `pc_load`=1, `pc_target`=`EXC_VECTOR`. Next state: IDLE.
- **IDLE → ERET:** taken when `req_eret` wins arbitration.
- **ERET:**
  - Outputs: `cp0_eret`=1, `pc_load`=1, `pc_target`=`epc_in` (combinational pass-through), `pipe_stall`=1, `pipe_flush`=1.
  - CP0 restores Status on this edge.
  - Next state: IDLE.
- **Idle outputs:** outside the listed states, every strobe is 0, and `cp0_cause`/`cp0_pc`/`pc_target` are 0.
- **irq as a level:** an irq still asserted after ERET returns is re-taken in IDLE, provided Status re-enables it.

## Timing
- **Reset:** state = IDLE, counter = 0, latched cause/PC = 0, all outputs 0. Reset applies immediately and mid-sequence. No CP0 strobe is issued after reset deasserts until a new request arrives.
- **Exception latency:**
  - Request seen at edge *n*.
  - `cp0_exception` is high in cycle *n*+1.
  - `pc_load` is high in cycle *n*+2+`FLUSH_CYCLES`.
  - `busy` is high for `FLUSH_CYCLES`+2 cycles in total.
- **ERET latency:** request seen at edge *n*; `cp0_eret`/`pc_load` high in cycle *n*+1; `busy` high for 1 cycle.
- **Strobe width:** all strobes are exactly one cycle wide.
- **Back-to-back:** a new request is accepted in the cycle directly after REDIRECT/ERET, i.e. on the first IDLE edge.
- **Simultaneity:** `req_syscall` and `irq_in` in the same cycle → cause 8 is taken and the irq is deferred while its level persists.
- **Status timing:** `status_in` is sampled only in IDLE. Changes during a sequence have no effect.

## Test plan
- **Syscall:** Status=32'h3, `req_syscall`=1, `req_pc`=32'h00400020 → next cycle `cp0_exception`=1, cause=8, `cp0_pc`=32'h00400020; with `FLUSH_CYCLES`=2, `pc_load`=1, `pc_target`=32'h00400004 four cycles after the request.
- **Masked break:** Status=32'h1, `req_break`=1 → no strobe, `busy` stays 0. Status=32'h5 → cause 9.
- **Priority:** Status=32'h1F with `req_teq`, `irq_in` and `req_eret` all asserted → cause 13 only; after return to IDLE with `irq_in` still high, irq is taken with cause 0.
- **ERET:** `req_eret`=1, `epc_in`=32'h0040003C → next cycle `cp0_eret`=1, `pc_load`=1, `pc_target`=32'h0040003C, `busy` high for one cycle.
- **Requests while busy:** pulse `req_break` during FLUSH → ignored, and no second `cp0_exception` is issued.
- **Reset mid-sequence:** assert `reset_in` during FLUSH → all outputs 0 asynchronously. After release, the state is IDLE and no `pc_load` occurs.
